simon_autoplayer: RTL
=====================

// Module: simon_autoplayer
// PURPOSE
//  Automatic player for the b12 memory game: the responder end of the game's nl/k interface.
//  Watches the game's LED outputs (nl) and loss flag (nloss), and records each flashed colour.
//  Once a playback ends, it replays the recorded colours on the key inputs (k).
//  It also issues the game start pulse. Sits beside the game in self-play/regression benches.
// PARAMETERS
//  SIZE_ADDRESS   5    sequence memory address width
//  SIZE_MEM       32   sequence memory depth (max recorded length)
//  GAP_MARGIN     8    extra all-off cycles beyond last on-pulse length that ends a playback
//  PRESS_TIMEOUT  255  max cycles a key is held waiting for its LED echo
// PORTS
//  clock    in   1  system clock, rising edge
//  reset_n  in   1  asynchronous active-low reset
//  go       in   1  request a new game (sampled in IDLE, WON, LOST)
//  blunder  in   1  when 1 at PRESS entry, press colour (c+1) mod 4 instead of c
//  nl       in   4  game LED outputs; bit c = colour c (0 red,1 green,2 yellow,3 blue)
//  nloss    in   1  game loss LED
//  start    out  1  one-cycle start pulse to the game
//  k        out  4  key outputs to the game, at most one bit high
//  length   out  6  number of colours recorded in the current/last playback (0..32)
//  busy     out  1  1 in START/LISTEN/PRESS/RELEASE
//  won      out  1  sticky until next go: game signalled win
//  lost     out  1  sticky until next go: game signalled loss or press timeout
//  ovf      out  1  sticky until next go: more than SIZE_MEM flashes seen in one playback
// BEHAVIOUR
//  Reset: state IDLE; start=0, k=0, length=0, busy=0, won=0, lost=0, ovf=0; all counters 0.
//  All outputs are registered; changes appear the cycle after the deciding edge.
//  nl_q = nl registered one cycle. A flash is nl one-hot && nl_q==0.
//  States and transitions:
//   IDLE: go=1 -> START; clear won/lost/ovf/length.
//   START: start=1 for exactly one cycle -> LISTEN, idle=0, onlen=0.
//   LISTEN: on a flash, write colour to mem[length], then length+1.
//    - If length==SIZE_MEM at a flash: no write, set ovf.
//    - While nl!=0: count onlen (reset at flash); idle=0.
//    - While nl==0: idle+1, saturating at 63.
//    - When idle==onlen+GAP_MARGIN && length>0 -> PRESS with idx=0.
//   PRESS: k=onehot(mem[idx], rotated by 1 if blunder sampled at entry); wait counter+1.
//    - nl==k -> RELEASE.
//    - wait==PRESS_TIMEOUT -> LOST.
//   RELEASE: k=0; wait for nl==0.
//    - If idx==length-1 -> LISTEN, with length=0, idle=0, onlen=0.
//    - Else idx+1 -> PRESS.
//   WON/LOST: k=0, busy=0; go=1 -> START, clearing flags and length.
//  Global priority, every cycle in START/LISTEN/PRESS/RELEASE:
//   1. nloss==1 -> LOST, set lost.
//   2. Else nl==4'b1111 -> WON, set won.
//   3. Else the state's own transition.
//  Simultaneous nloss and echo in PRESS: LOST wins. k is cleared the same cycle lost is set.
//  nl values that are nonzero and not one-hot (other than 4'b1111) are neither flashes nor echoes; they hold idle=0.
//  idx and length arithmetic: 6-bit unsigned, never wraps (length clamps at SIZE_MEM).
//  Memory: SIZE_MEM x 2-bit, written only in LISTEN; contents undefined after reset (never read before written).
//  reset_n low mid-operation: immediate return to reset values; the game is not notified.
// TESTING
//  1. Reset, go=1 one cycle -> start=1 exactly one cycle later, busy=1, k=0.
//  2. Drive nl: 4'b0100 for 34 cycles, then 0 for 50 cycles -> length=1; PRESS k=4'b0100 after idle==42; k=0 the cycle after nl=4'b0100 echo.
//  3. Two-flash playback (red, blue), echo each press -> k pulses 4'b0001 then 4'b1000; back to LISTEN, length reads 0.
//  4. blunder=1 during a red-only round -> k=4'b0010. Then drive nloss=1 -> lost=1, k=0 next cycle, busy=0.
//  5. nl=4'b1111 while LISTEN -> won=1, state WON. go=1 -> won cleared, start pulse.
//  6. 33 flashes in one playback -> length=32, ovf=1. Hold a press with no echo 255 cycles -> lost=1.
//  Closed loop with b12: full 32-round game -> won=1, nloss stays 0.

Source files
------------

// File: rtl/simon_autoplayer_if.sv
// Game-side signals of the b12 nl/k interface: LEDs and loss flag in, start pulse and keys out.
interface simon_autoplayer_if;
   logic [3:0] nl;
   logic       nloss;
   logic       start;
   logic [3:0] k;

   modport master (input nl, input nloss, output start, output k);
   modport slave  (output nl, output nloss, input start, input k);
endinterface

// File: rtl/simon_autoplayer.sv
// Self-playing responder for the b12 memory game: records each flashed colour during
// playback, then replays the recorded colours on the key outputs.
//
// state     | meaning
// S_IDLE    | after reset, waiting for go
// S_START   | start pulse to the game is high
// S_LISTEN  | recording flashes until the all-off gap ends the playback
// S_PRESS   | holding a key until the game echoes it on nl
// S_RELEASE | keys released, waiting for nl to go dark
// S_WON     | game signalled a win, waiting for go
// S_LOST    | game signalled a loss or a press timed out, waiting for go
module simon_autoplayer #(
   parameter int SIZE_ADDRESS  = 5,
   parameter int SIZE_MEM      = 32,
   parameter int GAP_MARGIN    = 8,
   parameter int PRESS_TIMEOUT = 255
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               go,
   input  logic               blunder,
   simon_autoplayer_if.master game,
   output logic [5:0]         length,
   output logic               busy,
   output logic               won,
   output logic               lost,
   output logic               ovf
);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_LISTEN, S_PRESS, S_RELEASE, S_WON, S_LOST
   } state_t;

   state_t     state;
   logic [3:0] nl_q;
   logic [5:0] idle;
   logic [5:0] onlen;
   logic [5:0] idx;
   logic [7:0] wait_cnt;
   logic [1:0] mem [SIZE_MEM];

   logic       nl_onehot;
   logic       flash;
   logic       in_game;
   logic       gap_done;
   logic       mem_we;
   logic [1:0] colour;
   logic [5:0] press_idx;
   logic [1:0] press_col;
   logic [3:0] press_k;

   assign nl_onehot = (game.nl != 4'b0000) && ((game.nl & (game.nl - 4'b0001)) == 4'b0000);
   assign flash     = nl_onehot && (nl_q == 4'b0000);
   assign in_game   = (state == S_START) || (state == S_LISTEN) ||
                      (state == S_PRESS) || (state == S_RELEASE);
   assign gap_done  = ({1'b0, idle} == ({1'b0, onlen} + 7'(GAP_MARGIN))) && (length != 6'd0);
   assign mem_we    = (state == S_LISTEN) && flash && !game.nloss && (length < 6'(SIZE_MEM));

   always_comb begin
      colour = 2'd0;
      case (game.nl)
         4'b0010: colour = 2'd1;
         4'b0100: colour = 2'd2;
         4'b1000: colour = 2'd3;
         default: colour = 2'd0;
      endcase
   end

   // Key for the press being entered this edge: first entry from LISTEN, next one from RELEASE.
   assign press_idx = (state == S_RELEASE) ? idx + 6'd1 : 6'd0;
   assign press_col = mem[press_idx[SIZE_ADDRESS-1:0]] + {1'b0, blunder};
   assign press_k   = 4'b0001 << press_col;

   always_ff @(posedge clock) begin
      if (mem_we) begin
         mem[length[SIZE_ADDRESS-1:0]] <= colour;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         nl_q       <= 4'b0000;
         game.start <= 1'b0;
         game.k     <= 4'b0000;
         length     <= 6'd0;
         busy       <= 1'b0;
         won        <= 1'b0;
         lost       <= 1'b0;
         ovf        <= 1'b0;
         idle       <= 6'd0;
         onlen      <= 6'd0;
         idx        <= 6'd0;
         wait_cnt   <= 8'd0;
      end else begin
         nl_q       <= game.nl;
         game.start <= 1'b0;
         if (in_game && game.nloss) begin
            state  <= S_LOST;
            lost   <= 1'b1;
            busy   <= 1'b0;
            game.k <= 4'b0000;
         end else if (in_game && (game.nl == 4'b1111)) begin
            state  <= S_WON;
            won    <= 1'b1;
            busy   <= 1'b0;
            game.k <= 4'b0000;
         end else begin
            case (state)
               S_IDLE, S_WON, S_LOST: begin
                  if (go) begin
                     state      <= S_START;
                     game.start <= 1'b1;
                     busy       <= 1'b1;
                     won        <= 1'b0;
                     lost       <= 1'b0;
                     ovf        <= 1'b0;
                     length     <= 6'd0;
                  end
               end
               S_START: begin
                  state <= S_LISTEN;
                  idle  <= 6'd0;
                  onlen <= 6'd0;
               end
               S_LISTEN: begin
                  if (flash) begin
                     if (length == 6'(SIZE_MEM)) ovf <= 1'b1;
                     else                        length <= length + 6'd1;
                  end
                  if (game.nl != 4'b0000) begin
                     idle <= 6'd0;
                     if (flash)               onlen <= 6'd1;
                     else if (onlen != 6'd63) onlen <= onlen + 6'd1;
                  end else if (idle != 6'd63) begin
                     idle <= idle + 6'd1;
                  end
                  if (gap_done) begin
                     state    <= S_PRESS;
                     idx      <= 6'd0;
                     wait_cnt <= 8'd0;
                     game.k   <= press_k;
                  end
               end
               S_PRESS: begin
                  if (game.nl == game.k) begin
                     state  <= S_RELEASE;
                     game.k <= 4'b0000;
                  end else if (wait_cnt == 8'(PRESS_TIMEOUT)) begin
                     state  <= S_LOST;
                     lost   <= 1'b1;
                     busy   <= 1'b0;
                     game.k <= 4'b0000;
                  end else begin
                     wait_cnt <= wait_cnt + 8'd1;
                  end
               end
               S_RELEASE: begin
                  if (game.nl == 4'b0000) begin
                     if (idx == length - 6'd1) begin
                        state  <= S_LISTEN;
                        length <= 6'd0;
                        idle   <= 6'd0;
                        onlen  <= 6'd0;
                     end else begin
                        state    <= S_PRESS;
                        idx      <= idx + 6'd1;
                        wait_cnt <= 8'd0;
                        game.k   <= press_k;
                     end
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
